mem_access_ctrl: RTL and testbench

// Downstream of mem_prep: issues one data-bus transaction per pipeline load/store using mem_prep's word address, replicated write data and strobe.

---
 rtl/mem_access_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Data-bus access controller: one outstanding transaction per pipeline load/store,
// with stall, load alignment/extension, bus-error, timeout and flush handling.
package defs_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_e;
endpackage

module mem_access_ctrl
    import defs_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  mem_width_e  mem_width_i,
    input  logic        mem_unsigned_i,
    input  logic [1:0]  mem_byte_idx_i,
    input  logic [31:0] mem_word_addr_i,
    input  logic [31:0] mem_write_data_i,
    input  logic [3:0]  mem_strobe_i,
    input  logic        mem_illegal_i,
    input  logic        flush_i,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_strb_o,
    output logic        bus_we_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] load_data_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] TO_LIM =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      addr_q, wdata_q, load_q, load_d, shifted, aligned;
    logic [3:0]       strb_q;
    logic             we_q, uns_q, pend_q, pend_d, fault_q;
    mem_width_e       width_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req, timeout, accept, to_done, to_fault;

    assign req     = mem_read_i | mem_write_i;
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LIM);

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        accept   = 1'b0;
        to_done  = 1'b0;
        to_fault = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A response still owed by a timed-out access is drained before new work.
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (!bus_rvalid_i) state_d = S_DRAIN;
                end else if (req && !flush_i) begin
                    if (mem_illegal_i) begin
                        state_d  = S_DONE;
                        to_done  = 1'b1;
                        to_fault = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        accept  = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (flush_i)          state_d = bus_ready_i ? S_DRAIN : S_IDLE;
                else if (bus_ready_i) state_d = S_WAIT;
                else if (timeout) begin
                    state_d  = S_DONE;
                    to_done  = 1'b1;
                    to_fault = 1'b1;
                end
            end
            S_WAIT: begin
                if (flush_i) state_d = bus_rvalid_i ? S_IDLE : S_DRAIN;
                else if (bus_rvalid_i) begin
                    state_d  = S_DONE;
                    to_done  = 1'b1;
                    to_fault = bus_err_i;
                end else if (timeout) begin
                    state_d  = S_DONE;
                    to_done  = 1'b1;
                    to_fault = 1'b1;
                    pend_d   = 1'b1;
                end
            end
            S_DRAIN: if (bus_rvalid_i) state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shifted = bus_rdata_i >> {idx_q, 3'b000};
        case (width_q)
            BYTE:    aligned = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            HALF:    aligned = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: aligned = bus_rdata_i;
        endcase
        load_d = (to_done && !to_fault && !we_q) ? aligned : '0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
            width_q <= BYTE;
            uns_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            fault_q <= to_fault;
            load_q  <= load_d;
            if (state_q == S_IDLE)                              cnt_q <= '0;
            else if (state_q == S_REQ || state_q == S_WAIT)     cnt_q <= cnt_q + 1'b1;
            if (accept) begin
                addr_q  <= mem_word_addr_i;
                wdata_q <= mem_write_data_i;
                strb_q  <= mem_write_i ? mem_strobe_i : 4'b0000;
                we_q    <= mem_write_i;
                width_q <= mem_width_i;
                uns_q   <= mem_unsigned_i;
                idx_q   <= mem_byte_idx_i;
            end
        end
    end

    // Reset gates the IDLE stall term so every output reads 0 while rst_ni is low.
    assign bus_valid_o = (state_q == S_REQ);
    assign bus_addr_o  = bus_valid_o ? addr_q  : '0;
    assign bus_wdata_o = bus_valid_o ? wdata_q : '0;
    assign bus_strb_o  = bus_valid_o ? strb_q  : '0;
    assign bus_we_o    = bus_valid_o & we_q;
    assign stall_o     = (state_q == S_REQ) || (state_q == S_WAIT) ||
                         ((state_q == S_IDLE) && req && !flush_i && rst_ni);
    assign done_o      = (state_q == S_DONE);
    assign fault_o     = done_o & fault_q;
    assign load_data_o = done_o ? load_q : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed corner cases plus randomized
// loads/stores compared against a behavioural load-alignment model.
module tb_mem_access_ctrl;
    import defs_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_read_i, mem_write_i, mem_unsigned_i, mem_illegal_i, flush_i;
    mem_width_e  mem_width_i;
    logic [1:0]  mem_byte_idx_i;
    logic [31:0] mem_word_addr_i, mem_write_data_i;
    logic [3:0]  mem_strobe_i;
    logic        bus_valid_o, bus_ready_i, bus_we_o, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_strb_o;
    logic        stall_o, done_o, fault_o;
    logic [31:0] load_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .mem_width_i(mem_width_i), .mem_unsigned_i(mem_unsigned_i),
        .mem_byte_idx_i(mem_byte_idx_i), .mem_word_addr_i(mem_word_addr_i),
        .mem_write_data_i(mem_write_data_i), .mem_strobe_i(mem_strobe_i),
        .mem_illegal_i(mem_illegal_i), .flush_i(flush_i),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_strb_o(bus_strb_o), .bus_we_o(bus_we_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .bus_err_i(bus_err_i), .stall_o(stall_o), .done_o(done_o),
        .fault_o(fault_o), .load_data_o(load_data_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected load result from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] model_load(input logic wr, input logic flt, input mem_width_e w,
                                               input logic uns, input logic [1:0] idx,
                                               input logic [31:0] rdata);
        longint v;
        if (wr || flt) return 32'd0;
        v = longint'(rdata >> (8 * idx));
        case (w)
            BYTE: begin v = v % 256;   if (!uns && v >= 128)   v = v - 256;   end
            HALF: begin v = v % 65536; if (!uns && v >= 32768) v = v - 65536; end
            default: v = longint'(rdata);
        endcase
        return v[31:0];
    endfunction

    task automatic drive_req(input logic wr, input mem_width_e w, input logic uns,
                             input logic [1:0] idx, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb, input logic ill);
        mem_read_i       = !wr;
        mem_write_i      = wr;
        mem_width_i      = w;
        mem_unsigned_i   = uns;
        mem_byte_idx_i   = idx;
        mem_word_addr_i  = addr;
        mem_write_data_i = wdata;
        mem_strobe_i     = strb;
        mem_illegal_i    = ill;
    endtask

    task automatic drop_req();
        mem_read_i    = 1'b0;
        mem_write_i   = 1'b0;
        mem_illegal_i = 1'b0;
    endtask

    // Full access: ready after rdly extra REQ cycles, response vdly cycles after handshake.
    task automatic do_access(input string tag, input logic wr, input mem_width_e w, input logic uns,
                             input logic [1:0] idx, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb,
                             input logic [31:0] rdata, input logic err, input int rdly, input int vdly);
        logic [31:0] exp_ld;
        exp_ld = model_load(wr, err, w, uns, idx, rdata);
        @(negedge clk_i);
        drive_req(wr, w, uns, idx, addr, wdata, strb, 1'b0);
        #1;
        check({tag, "/stall_idle"}, stall_o, 1);
        check({tag, "/valid_idle"}, bus_valid_o, 0);
        for (int i = 0; i <= rdly; i++) begin
            @(negedge clk_i);
            check({tag, "/valid"}, bus_valid_o, 1);
            check({tag, "/addr"}, bus_addr_o, addr);
            check({tag, "/we"}, bus_we_o, wr);
            check({tag, "/strb"}, bus_strb_o, wr ? strb : 4'b0000);
            if (wr) check({tag, "/wdata"}, bus_wdata_o, wdata);
            check({tag, "/stall_req"}, stall_o, 1);
            if (i == rdly) bus_ready_i = 1'b1;
        end
        @(negedge clk_i);
        bus_ready_i = 1'b0;
        for (int j = 1; j <= vdly; j++) begin
            if (j > 1) @(negedge clk_i);
            check({tag, "/valid_wait"}, bus_valid_o, 0);
            check({tag, "/stall_wait"}, stall_o, 1);
            check({tag, "/done_wait"}, done_o, 0);
            if (j == vdly) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = rdata;
                bus_err_i    = err;
            end
        end
        @(negedge clk_i);
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
        bus_rdata_i  = $urandom;
        check({tag, "/done"}, done_o, 1);
        check({tag, "/stall_done"}, stall_o, 0);
        check({tag, "/fault"}, fault_o, err);
        check({tag, "/load"}, load_data_o, exp_ld);
        drop_req();
        @(negedge clk_i);
        check({tag, "/done_after"}, done_o, 0);
    endtask

    initial begin
        logic        r_wr, r_uns, r_err;
        mem_width_e  r_w;
        logic [1:0]  r_idx;
        logic [3:0]  r_strb;

        rst_ni = 1'b0;
        drive_req(1'b1, WORD, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 1'b0);
        mem_read_i   = 1'b1;
        mem_write_i  = 1'b0;
        flush_i      = 1'b0;
        bus_ready_i  = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
        bus_err_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst/valid", bus_valid_o, 0);
        check("rst/stall", stall_o, 0);
        check("rst/done", done_o, 0);
        check("rst/fault", fault_o, 0);
        check("rst/load", load_data_o, 0);
        check("rst/addr", bus_addr_o, 0);
        drop_req();
        rst_ni = 1'b1;

        do_access("lw", 1'b0, WORD, 1'b0, 2'd0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, 2);
        do_access("lb", 1'b0, BYTE, 1'b0, 2'd3, 32'h104, 32'h0, 4'h0, 32'h80FF_FFFF, 1'b0, 1, 1);
        do_access("lhu", 1'b0, HALF, 1'b1, 2'd2, 32'h108, 32'h0, 4'h0, 32'h8001_0000, 1'b0, 0, 1);
        do_access("sb", 1'b1, BYTE, 1'b0, 2'd2, 32'h10C, 32'hABABABAB, 4'b0100, 32'h5555_5555, 1'b0, 3, 1);
        do_access("err", 1'b0, WORD, 1'b0, 2'd0, 32'h110, 32'h0, 4'h0, 32'h1234_5678, 1'b1, 0, 1);

        // Illegal access: fault without touching the bus.
        @(negedge clk_i);
        drive_req(1'b0, HALF, 1'b0, 2'd1, 32'h200, 32'h0, 4'h0, 1'b1);
        #1 check("ill/stall", stall_o, 1);
        @(negedge clk_i);
        check("ill/valid", bus_valid_o, 0);
        check("ill/done", done_o, 1);
        check("ill/fault", fault_o, 1);
        check("ill/load", load_data_o, 0);
        drop_req();
        @(negedge clk_i);
        check("ill/done_after", done_o, 0);

        // Flush during WAIT, late response drained, next request held off until then.
        @(negedge clk_i);
        drive_req(1'b0, WORD, 1'b0, 2'd0, 32'h200, 32'h0, 4'h0, 1'b0);
        @(negedge clk_i);
        check("fl/valid", bus_valid_o, 1);
        bus_ready_i = 1'b1;
        @(negedge clk_i);
        bus_ready_i = 1'b0;
        flush_i = 1'b1;
        drop_req();
        @(negedge clk_i);
        check("fl/stall_drain", stall_o, 0);
        check("fl/done_drain", done_o, 0);
        flush_i = 1'b0;
        drive_req(1'b0, WORD, 1'b0, 2'd0, 32'h300, 32'h0, 4'h0, 1'b0);
        @(negedge clk_i);
        check("fl/no_accept1", bus_valid_o, 0);
        check("fl/stall_drain2", stall_o, 0);
        @(negedge clk_i);
        check("fl/no_accept2", bus_valid_o, 0);
        check("fl/done_drain2", done_o, 0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hBAD0_BAD0;
        @(negedge clk_i);
        bus_rvalid_i = 1'b0;
        check("fl/done_discard", done_o, 0);
        check("fl/valid_idle", bus_valid_o, 0);
        check("fl/stall_idle", stall_o, 1);
        @(negedge clk_i);
        check("fl/valid_next", bus_valid_o, 1);
        check("fl/addr_next", bus_addr_o, 32'h300);
        bus_ready_i = 1'b1;
        @(negedge clk_i);
        bus_ready_i  = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1234_5678;
        @(negedge clk_i);
        bus_rvalid_i = 1'b0;
        check("fl/done_next", done_o, 1);
        check("fl/load_next", load_data_o, 32'h1234_5678);
        drop_req();

        // Timeout: ready never comes, fault after 8 REQ cycles.
        @(negedge clk_i);
        drive_req(1'b0, WORD, 1'b0, 2'd0, 32'h400, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            check("to/valid", bus_valid_o, 1);
            check("to/done_early", done_o, 0);
        end
        @(negedge clk_i);
        check("to/done", done_o, 1);
        check("to/fault", fault_o, 1);
        check("to/valid_off", bus_valid_o, 0);
        check("to/load", load_data_o, 0);
        drop_req();
        @(negedge clk_i);

        // Asynchronous reset while waiting for a response.
        drive_req(1'b0, WORD, 1'b0, 2'd0, 32'h500, 32'h0, 4'h0, 1'b0);
        @(negedge clk_i);
        bus_ready_i = 1'b1;
        @(negedge clk_i);
        bus_ready_i = 1'b0;
        check("rw/stall_wait", stall_o, 1);
        #1 rst_ni = 1'b0;
        #1;
        check("rw/stall", stall_o, 0);
        check("rw/valid", bus_valid_o, 0);
        check("rw/done", done_o, 0);
        check("rw/fault", fault_o, 0);
        check("rw/load", load_data_o, 0);
        drop_req();
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int n = 0; n < 40; n++) begin
            r_wr  = 1'($urandom_range(0, 1));
            r_w   = mem_width_e'($urandom_range(0, 2));
            r_uns = 1'($urandom_range(0, 1));
            r_err = ($urandom_range(0, 7) == 0);
            case (r_w)
                BYTE:    begin r_idx = 2'($urandom_range(0, 3));     r_strb = 4'b0001 << r_idx; end
                HALF:    begin r_idx = 2'($urandom_range(0, 1) * 2); r_strb = 4'b0011 << r_idx; end
                default: begin r_idx = 2'd0;                          r_strb = 4'b1111;          end
            endcase
            do_access("rand", r_wr, r_w, r_uns, r_idx, {$urandom} & 32'hFFFF_FFFC, $urandom,
                      r_strb, $urandom, r_err, $urandom_range(0, 2), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
